multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_out_decode.sv | 81 ++++++++
 rtl/multicycle_control.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control FSM.
// The JUMP state exists only when MC_JUMP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REXE,
    S_RWB,
    S_BEQ,
    S_ADDIEX,
    S_ADDIWB,
    S_HALT
`ifdef MC_JUMP_EN
    , S_JUMP
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode of the control FSM state; mem_ready only qualifies the
// strobes of states that wait on memory.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   illegal_nop,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_SHIFT;
        ctrl.alu_op     = ALU_ADD;
        ctrl.instr_done = illegal_nop;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_REXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register, latched opcode and next-state logic.
// Define MC_JUMP_EN to add the j instruction (JUMP state); otherwise opcode 000010 is illegal.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ALUOP_W      = 2,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                halted,
  output state_t              fsm_state
);

  state_t              state;
  state_t              next_state;
  logic [OPCODE_W-1:0] op_q;
  logic                legal_op;
  ctrl_t               ctrl_raw;
  ctrl_t               ctrl;

  function automatic logic op_is(input logic [OPCODE_W-1:0] v, input logic [5:0] c);
    return v == OPCODE_W'(c);
  endfunction

  always_comb begin
    legal_op = op_is(opcode, OP_RTYPE) || op_is(opcode, OP_LW) || op_is(opcode, OP_SW) ||
               op_is(opcode, OP_BEQ) || op_is(opcode, OP_ADDI);
`ifdef MC_JUMP_EN
    if (op_is(opcode, OP_J)) legal_op = 1'b1;
`endif
  end

  // Memory request stays up until mem_ready; a transfer completes in the
  // cycle where request and mem_ready are both high, and only then do we move on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (!legal_op)                                         next_state = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
        else if (op_is(opcode, OP_RTYPE))                      next_state = S_REXE;
        else if (op_is(opcode, OP_LW) || op_is(opcode, OP_SW)) next_state = S_MEMADR;
        else if (op_is(opcode, OP_BEQ))                        next_state = S_BEQ;
        else if (op_is(opcode, OP_ADDI))                       next_state = S_ADDIEX;
`ifdef MC_JUMP_EN
        else                                                   next_state = S_JUMP;
`else
        else                                                   next_state = S_FETCH;
`endif
      end
      S_MEMADR: next_state = op_is(op_q, OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_REXE:   next_state = S_RWB;
      S_RWB:    next_state = S_FETCH;
      S_BEQ:    next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   next_state = S_FETCH;
`endif
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  mc_out_decode u_decode (
    .state       (state),
    .mem_ready   (mem_ready),
    .illegal_nop (!legal_op && (ILLEGAL_HALT == 0)),
    .ctrl        (ctrl_raw)
  );

  // Reset forces every strobe low in the reset cycle itself, aborting any instruction.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl.alu_op);
  assign pc_src        = ctrl.pc_src;
  assign instr_done    = ctrl.instr_done;
  assign halted        = ctrl.halted;
  assign fsm_state     = state;

endmodule
